// File: rtl/grayscale_pkg.sv
// Shared types and constants for the grayscale controller and its
// RGB-to-luminance pipeline. Optional statistics are enabled by
// defining GRAYSCALE_CTRL_STATS_EN (see grayscale_ctrl.sv).
package grayscale_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Pixel layout: {R, G, B}, 8 bits per channel
  localparam int CH_W  = 8;
  localparam int PIX_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // 3 * 255 = 765 fits in 10 bits, so the channel sum never overflows
  localparam int SUM_W = 10;

  // Pipeline depth of the sum/divide stage
  localparam int STAGES = 2;

  localparam logic [SUM_W-1:0] GRAY_DIV = 10'd3;

  // R + G + B, widened before the add so no carry is lost
  function automatic logic [SUM_W-1:0] rgb_sum(input logic [PIX_W-1:0] p);
    return SUM_W'(p[R_LSB +: CH_W]) + SUM_W'(p[G_LSB +: CH_W]) +
           SUM_W'(p[B_LSB +: CH_W]);
  endfunction

endpackage

// File: rtl/grayscale_ctrl_rgb_to_gray.sv
// Two-stage RGB -> gray pipeline: stage 1 sums the channels, stage 2
// divides by three. en_i freezes both stages (data and valids) so a
// stalled output write keeps its pixel and nothing behind it advances.
module rgb_to_gray
  import grayscale_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic             s1_vld_o,
  output logic             vld_o,
  output logic [CH_W-1:0]  gray_o
);

  // vld_pipe_q[k] is the valid bit of stage k
  logic [STAGES:1]  vld_pipe_q;
  logic [SUM_W-1:0] sum_q;
  logic [CH_W-1:0]  gray_q;

  // Valid shift register, advanced only when the consumer can accept
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
    end else if (en_i) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], vld_i};
    end
  end

  // Stage 1: channel sum, loaded only for real pixels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (en_i && vld_i) begin
      sum_q <= rgb_sum(pix_i);
    end
  end

  // Stage 2: exact floor divide; result always in 0..255. Holding on
  // bubbles keeps the output word stable between pixels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gray_q <= '0;
    end else if (en_i && vld_pipe_q[1]) begin
      gray_q <= CH_W'(sum_q / GRAY_DIV);
    end
  end

  assign s1_vld_o = vld_pipe_q[1];
  assign vld_o    = vld_pipe_q[STAGES];
  assign gray_o   = gray_q;

endmodule

// File: rtl/grayscale_ctrl.sv
// Frame sequencer for the grayscale stage: pops W*H RGB pixels from a
// show-ahead input FIFO, pushes gray pixels into the output FIFO, and
// pulses frame_done once the last pixel has been written.
// Optional: define GRAYSCALE_CTRL_STATS_EN to add stall/starve counters.
module grayscale_ctrl
  import grayscale_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  input  logic [PIX_W-1:0] in_dout,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic [CH_W-1:0]  out_din,
  input  logic             out_full,
  output logic             out_wr_en
`ifdef GRAYSCALE_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      starve_cycles
`endif
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_left_q, pix_left_d;

  logic advance;
  logic pop;
  logic s1_valid;
  logic s2_valid;
  logic pipe_empty;

  // Pipeline moves unless a finished pixel is blocked by a full output FIFO
  assign advance    = !(s2_valid && out_full);
  assign pop        = (state_q == ST_RUN) && !in_empty && advance &&
                      (pix_left_q != '0);
  assign pipe_empty = !s1_valid && !s2_valid;

  assign in_rd_en  = pop;
  assign out_wr_en = s2_valid && !out_full;

  rgb_to_gray u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (advance),
    .vld_i    (pop),
    .pix_i    (in_dout),
    .s1_vld_o (s1_valid),
    .vld_o    (s2_valid),
    .gray_o   (out_din)
  );

  // State and pixel-counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pix_left_q <= '0;
    end else begin
      state_q    <= state_d;
      pix_left_q <= pix_left_d;
    end
  end

  // Next state, pixel countdown and the frame_done pulse
  always_comb begin
    state_d    = state_q;
    pix_left_d = pix_left_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          pix_left_d = NPIX_C;
        end
      end
      ST_RUN: begin
        if (pop) begin
          pix_left_d = pix_left_q - ONE_C;
          if (pix_left_q == ONE_C) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pipe_empty) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy drops together with the frame_done pulse so the sequencer sees a
  // clean handoff in a single cycle
  assign busy = (state_q != ST_IDLE) && !frame_done;

`ifdef GRAYSCALE_CTRL_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] starve_q;

  // Saturating stall/starve counters, cleared when a frame is accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (state_q != ST_IDLE && !advance && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (state_q == ST_RUN && in_empty && pix_left_q != '0 && starve_q != '1)
        starve_q <= starve_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif

endmodule
